// File: rtl/gcd_engine.sv
// ---------------------------------------------------------------------------
// gcd_engine
//   Iterative subtractive greatest-common-divisor engine. A host loads two
//   unsigned operands with a one-cycle strobe. The engine then performs one
//   subtract or swap step per clock until register y reaches zero. At that
//   point register x holds the GCD.
//
//   Host protocol (no handshake, no backpressure):
//   - io_loadingValues=1 at a rising edge captures io_value1/io_value2.
//     This restarts the engine unconditionally.
//   - io_outputValid is a level flag that is high whenever y == 0.
//     While it is high, io_outputGCD is the result. Both stay stable until
//     the next load or reset.
//   - A host that wants the result must not reload before
//     io_outputValid rises.
//
// Parameters
//   WIDTH             operand/result width in bits (unsigned), >= 1
//
// Ports
//   clock             in   1      rising-edge clock
//   reset             in   1      synchronous, active-high reset (x=y=0)
//   io_value1         in   WIDTH  operand A, sampled on load
//   io_value2         in   WIDTH  operand B, sampled on load
//   io_loadingValues  in   1      load strobe
//   io_outputGCD      out  WIDTH  register x (the GCD once valid)
//   io_outputValid    out  1      high when register y == 0
// ---------------------------------------------------------------------------
module gcd_engine #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_value1,
  input  logic [WIDTH-1:0] io_value2,
  input  logic             io_loadingValues,
  output logic [WIDTH-1:0] io_outputGCD,
  output logic             io_outputValid
);

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;

  logic w_x_gt_y;
  logic w_x_zero;
  logic w_y_zero;

  assign w_x_gt_y = (r_x > r_y);
  assign w_x_zero = (r_x == '0);
  assign w_y_zero = (r_y == '0);

  // Every step subtracts the smaller register from the larger, so the
  // subtraction cannot underflow. Once y is zero with x nonzero, the x > y
  // branch subtracts zero. This holds the result without a separate
  // done state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (io_loadingValues) begin
      r_x <= io_value1;
      r_y <= io_value2;
    end else if (w_x_gt_y) begin
      r_x <= r_x - r_y;
    end else if (w_x_zero && !w_y_zero) begin
      // gcd(0, n) = n: move y into x so the engine terminates.
      r_x <= r_y;
      r_y <= '0;
    end else begin
      // 0 < x <= y, or x == y == 0. The latter subtracts zero and idles.
      r_y <= r_y - r_x;
    end
  end

  assign io_outputGCD   = r_x;
  assign io_outputValid = w_y_zero;

endmodule

// File: tb/tb_gcd_engine.sv
module tb_gcd_engine;

  localparam int WIDTH = 2;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] io_value1 = '0;
  logic [WIDTH-1:0] io_value2 = '0;
  logic             io_loadingValues = 1'b0;
  logic [WIDTH-1:0] io_outputGCD;
  logic             io_outputValid;

  always #5 clock = ~clock;

  gcd_engine #(.WIDTH(WIDTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_value1        (io_value1),
    .io_value2        (io_value2),
    .io_loadingValues (io_loadingValues),
    .io_outputGCD     (io_outputGCD),
    .io_outputValid   (io_outputValid)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] g;
    int               lat;  // cycles after the load edge until valid
  } vec_t;

  vec_t vecs[14];

  // Reference: Euclid by remainder, independent of the subtractive datapath.
  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    io_value1        = a;
    io_value2        = b;
    io_loadingValues = 1'b1;
    tick();
    io_loadingValues = 1'b0;
  endtask

  // Called right after do_load; cycles = 1 means valid on the first cycle.
  task automatic wait_valid(input int budget, output int cycles);
    cycles = 1;
    while (!io_outputValid && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c;
    logic [WIDTH-1:0] ra, rb, rc, rd;

    vecs[0]  = '{a: 2'd3, b: 2'd1, g: 2'd1, lat: 4};
    vecs[1]  = '{a: 2'd1, b: 2'd3, g: 2'd1, lat: 4};
    vecs[2]  = '{a: 2'd2, b: 2'd2, g: 2'd2, lat: 2};
    vecs[3]  = '{a: 2'd2, b: 2'd0, g: 2'd2, lat: 1};
    vecs[4]  = '{a: 2'd0, b: 2'd3, g: 2'd3, lat: 2};
    vecs[5]  = '{a: 2'd0, b: 2'd0, g: 2'd0, lat: 1};
    vecs[6]  = '{a: 2'd3, b: 2'd2, g: 2'd1, lat: 4};
    vecs[7]  = '{a: 2'd2, b: 2'd3, g: 2'd1, lat: 4};
    vecs[8]  = '{a: 2'd2, b: 2'd1, g: 2'd1, lat: 3};
    vecs[9]  = '{a: 2'd1, b: 2'd2, g: 2'd1, lat: 3};
    vecs[10] = '{a: 2'd3, b: 2'd3, g: 2'd3, lat: 2};
    vecs[11] = '{a: 2'd0, b: 2'd1, g: 2'd1, lat: 2};
    vecs[12] = '{a: 2'd3, b: 2'd0, g: 2'd3, lat: 1};
    vecs[13] = '{a: 2'd1, b: 2'd1, g: 2'd1, lat: 2};

    // Reset held for two cycles.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_valid", io_outputValid, 1);
    check("reset_gcd", io_outputGCD, 0);

    // (3,1) cycle by cycle, then idle hold.
    do_load(2'd3, 2'd1);
    check("seq31_c1_gcd", io_outputGCD, 3);
    check("seq31_c1_valid", io_outputValid, 0);
    tick();
    check("seq31_c2_gcd", io_outputGCD, 2);
    check("seq31_c2_valid", io_outputValid, 0);
    tick();
    check("seq31_c3_gcd", io_outputGCD, 1);
    check("seq31_c3_valid", io_outputValid, 0);
    tick();
    check("seq31_c4_gcd", io_outputGCD, 1);
    check("seq31_c4_valid", io_outputValid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq31_idle_gcd", io_outputGCD, 1);
      check("seq31_idle_valid", io_outputValid, 1);
    end

    // Table-driven vectors with exact latency and result hold.
    foreach (vecs[i]) begin
      do_load(vecs[i].a, vecs[i].b);
      wait_valid(8, c);
      check("tbl_valid", io_outputValid, 1);
      check("tbl_latency", c, vecs[i].lat);
      check("tbl_gcd", io_outputGCD, vecs[i].g);
      tick();
      tick();
      check("tbl_hold_gcd", io_outputGCD, vecs[i].g);
      check("tbl_hold_valid", io_outputValid, 1);
    end

    // Exhaustive sweep against the reference model.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        do_load(WIDTH'(a), WIDTH'(b));
        wait_valid(4, c);
        check("sweep_valid_in_4", io_outputValid, 1);
        check("sweep_gcd", io_outputGCD, ref_gcd(a, b));
      end
    end

    // Reset mid-computation of (3,1).
    do_load(2'd3, 2'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_gcd", io_outputGCD, 0);
    check("midreset_valid", io_outputValid, 1);

    // Loading held high: the registers reload every edge.
    io_value1        = 2'd3;
    io_value2        = 2'd1;
    io_loadingValues = 1'b1;
    tick();
    tick();
    tick();
    check("loadheld_gcd", io_outputGCD, 3);
    check("loadheld_valid", io_outputValid, 0);
    io_loadingValues = 1'b0;
    wait_valid(8, c);
    check("loadheld_done_gcd", io_outputGCD, 1);

    // Directed reload mid-computation: the new operands win.
    do_load(2'd3, 2'd1);
    tick();
    do_load(2'd2, 2'd2);
    check("reload_c1_gcd", io_outputGCD, 2);
    wait_valid(8, c);
    check("reload_latency", c, 2);
    check("reload_gcd", io_outputGCD, 2);

    // Randomized loads, some interrupted by a reload, via the scoreboard.
    for (int k = 0; k < 40; k++) begin
      ra = WIDTH'($urandom_range(0, 3));
      rb = WIDTH'($urandom_range(0, 3));
      do_load(ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int j = 0; j < gap; j++) tick();
        rc = WIDTH'($urandom_range(0, 3));
        rd = WIDTH'($urandom_range(0, 3));
        do_load(rc, rd);
        exp_q.push_back(WIDTH'(ref_gcd(int'(rc), int'(rd))));
      end else begin
        exp_q.push_back(WIDTH'(ref_gcd(int'(ra), int'(rb))));
      end
      wait_valid(8, c);
      check("rand_valid", io_outputValid, 1);
      check("rand_gcd", io_outputGCD, exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
